// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM state codes,
// primary opcode constants, ALUOp encodings (also consumed by ALU_Control)
// and the packed control-word bundle produced by the output decoder.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       alu_src_a;
        logic       branch;
        logic       mem_to_reg;
        logic       reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/ctrl_output_decode.sv
// Moore output map: converts the current FSM state into the datapath control
// word. The only non-state input is MemReady, which gates the FETCH-cycle
// PC/IR write enables so an instruction is latched only once memory delivers.
// Ports:
//   i_state     current FSM state
//   i_mem_ready memory access completes this cycle
//   o_ctrl      control word (all fields 0 for unused state codes)
module ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.alu_src_b = 2'b01;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: o_ctrl.alu_src_b = 2'b11;
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
            end
            S_MEMRD: o_ctrl.iord = 1'b1;
            S_MEMWB: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            // MemWrite stays high for every MEMWR cycle until memory accepts
            S_MEMWR: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNC;
            end
            S_ALUWB: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_SUB;
                o_ctrl.pc_src    = 2'b01;
                o_ctrl.branch    = 1'b1;
            end
            S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
            end
            S_ADDIWB: o_ctrl.reg_write = 1'b1;
            S_JUMP: begin
                o_ctrl.pc_src   = 2'b10;
                o_ctrl.pc_write = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control unit (Moore FSM).
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   Opcode[5:0]         instruction bits [31:26]
//   MemReady            memory access completes this cycle
//   PCWrite..RegDst     datapath control strobes/selects
//   ALUSrcB, PCSrc, ALUOp  2-bit selects (ALUOp feeds ALU_Control)
//   IllegalOp           one-cycle pulse in DECODE for an unsupported opcode
//   State[3:0]          current state code
module main_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       Branch,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       IllegalOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic [3:0] State
);

    state_t r_state;
    state_t w_next;
    logic   w_illegal;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = S_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:  w_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (Opcode == OP_LW)      w_next = S_MEMRD;
                else if (Opcode == OP_SW) w_next = S_MEMWR;
                else                      w_next = S_FETCH;
            end
            S_MEMRD:   w_next = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = MemReady ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    ctrl_output_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (MemReady),
        .o_ctrl      (w_ctrl)
    );

    // Architectural-state write enables are masked while reset is held so a
    // mid-instruction reset cannot commit a stale write on the reset edge.
    assign PCWrite   = w_ctrl.pc_write  & ~reset;
    assign IRWrite   = w_ctrl.ir_write  & ~reset;
    assign MemWrite  = w_ctrl.mem_write & ~reset;
    assign RegWrite  = w_ctrl.reg_write & ~reset;
    assign IllegalOp = w_illegal        & ~reset;
    assign IorD      = w_ctrl.iord;
    assign ALUSrcA   = w_ctrl.alu_src_a;
    assign Branch    = w_ctrl.branch;
    assign MemtoReg  = w_ctrl.mem_to_reg;
    assign RegDst    = w_ctrl.reg_dst;
    assign ALUSrcB   = w_ctrl.alu_src_b;
    assign PCSrc     = w_ctrl.pc_src;
    assign ALUOp     = w_ctrl.alu_op;
    assign State     = r_state;

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: Opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-004 SHALL have port: MemReady  input  1  memory access completes this cycle when 1.
REQ-005 SHALL have outputs (1 bit each): PCWrite, IRWrite, MemWrite, RegWrite, IorD, ALUSrcA, Branch, MemtoReg, RegDst, IllegalOp.
REQ-006 SHALL have outputs (2 bits each): ALUSrcB, PCSrc, ALUOp; ALUOp drives ALU_Control directly (00 add, 01 subtract, 10 decode FuncCode).
REQ-007 SHALL have output: State  output  4  current state code, for debug and bench.

Function
REQ-008 SHALL be a Moore FSM with state codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-009 SHALL decode Opcodes: LW 100011, SW 101011, R-type 000000, BEQ 000100, ADDI 001000, J 000010.
REQ-010 SHALL transition FETCH->DECODE only when MemReady=1; otherwise SHALL hold FETCH.
REQ-011 SHALL transition from DECODE on Opcode sampled that cycle: LW/SW->MEMADR, R->EXECUTE, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, any other->FETCH.
REQ-012 SHALL transition MEMADR->MEMRD for LW, MEMADR->MEMWR for SW (Opcode re-sampled in MEMADR).
REQ-013 SHALL transition MEMRD->MEMWB and MEMWR->FETCH only when MemReady=1; otherwise SHALL hold.
REQ-014 SHALL transition MEMWB, ALUWB, ADDIWB, BRANCH, JUMP ->FETCH unconditionally; EXECUTE->ALUWB; ADDIEX->ADDIWB.
REQ-015 SHALL treat unused codes 12-15 as illegal: all outputs 0, next state FETCH.
REQ-016 SHALL drive, per state (unlisted outputs 0): FETCH ALUSrcB=01, IRWrite=PCWrite=MemReady; DECODE ALUSrcB=11; MEMADR ALUSrcA=1, ALUSrcB=10; MEMRD IorD=1; MEMWB MemtoReg=1, RegWrite=1; MEMWR IorD=1, MemWrite=1; EXECUTE ALUSrcA=1, ALUOp=10; ALUWB RegDst=1, RegWrite=1; BRANCH ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1; ADDIEX ALUSrcA=1, ALUSrcB=10; ADDIWB RegWrite=1; JUMP PCSrc=10, PCWrite=1.
REQ-017 SHALL pulse IllegalOp for exactly the DECODE cycle in which Opcode is unsupported; no write enable asserted during it.
REQ-018 SHALL keep MemWrite asserted for every MEMWR cycle while MemReady=0 (write held until accepted).
REQ-019 SHALL give instruction latencies (MemReady tied 1): LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3 cycles.

Reset
REQ-020 SHALL enter FETCH on any clock edge with reset=1, including mid-instruction; reset overrides MemReady and Opcode.
REQ-021 SHALL, while reset=1, force PCWrite, IRWrite, MemWrite, RegWrite and IllegalOp to 0; on the first edge after reset deasserts, behave as FETCH.
REQ-022 SHALL, after reset, present State=0 and all other outputs at their FETCH values.

Structure
REQ-023 SHALL place state codes, opcode constants and ALUOp encodings in a shared package mips_ctrl_pkg, also used by ALU_Control.
REQ-024 SHALL use two parts: state register plus next-state logic, and one sub-module ctrl_output_decode (pure state-to-output map, MemReady gating only).
REQ-025 SHALL be 120-400 lines of RTL total.

Verification
REQ-026 SHALL check LW, MemReady=1, Opcode=100011: State 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-027 SHALL check SW with MemReady=0 for 3 cycles in MEMWR: State holds 5 with MemWrite=1 for 4 cycles total, then returns to 0.
REQ-028 SHALL check R-type Opcode=000000: ALUOp=10 in state 6, RegDst=1 with RegWrite=1 in state 7, back to 0 after 4 cycles.
REQ-029 SHALL check BEQ Opcode=000100 gives ALUOp=01, PCSrc=01, Branch=1 in state 8; J Opcode=000010 gives PCSrc=10, PCWrite=1 in state 11.
REQ-030 SHALL check Opcode=111111 in DECODE: IllegalOp=1 for one cycle, next State=0, no write enables.
REQ-031 SHALL check reset=1 asserted in state 3: next State=0, MemWrite=RegWrite=0, FETCH resumes when reset falls.
